risc_controller: RTL and testbench
==================================

Name: risc_controller

Overview:
- Instruction-sequencing control unit for the 8-bit accumulator datapath.
- An 8-phase cycle counter decodes the 3-bit opcode from the instruction register and the ALU zero flag into per-phase control strobes.
- Strobes: memory select/read/write, instruction-register load, PC increment/load, data-bus enable, and accumulator load (`ld_ac`).
- Includes a sticky HALT state with a `resume` handshake.

Parameters:
- none; widths are fixed by the ISA (opcode 3 bits, phase 3 bits). Constants live in the shared package.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  3  opcode field of the instruction register, valid from phase OP_ADDR onward
- zero  in  1  accumulator-is-zero flag from the ALU
- resume  in  1  single-cycle pulse; leaves HALTED
- sel  out  1  memory address mux: 1 = PC, 0 = IR operand
- rd  out  1  memory read
- wr  out  1  memory write
- ld_ir  out  1  load instruction register
- inc_pc  out  1  increment PC
- ld_pc  out  1  load PC from IR operand
- data_e  out  1  drive accumulator onto data bus
- ld_ac  out  1  load accumulator
- halt  out  1  controller halted
- phase  out  3  current phase, for debug and testbench

Behaviour:
- State: 3-bit `phase` register plus 1-bit `halted` flag. Both are reset asynchronously to `phase` = INST_ADDR(0) and `halted` = 0.
- Reset output values: `sel` = 1; every other output = 0.
- Phase sequence, when not halted: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- The phase advances by 1 each clock and wraps from 7 to 0.
- Outputs are combinational decode of registered `phase`, `halted`, `opcode` and `zero`. No output has added latency.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD | AND | XOR | LDA.
- Per-phase decode (signals not listed are 0):
  - INST_ADDR: `sel`.
  - INST_FETCH: `sel`, `rd`.
  - INST_LOAD and IDLE: `sel`, `rd`, `ld_ir`.
  - OP_ADDR: `inc_pc`; `halt` = (`opcode` == HLT).
  - OP_FETCH: `rd` = ALUOP.
  - ALU_OP: `rd` = ALUOP; `inc_pc` = SKZ & `zero`; `ld_pc` = JMP; `data_e` = STO.
  - STORE: `rd` = ALUOP; `ld_ac` = ALUOP; `ld_pc` = JMP; `wr` = STO; `data_e` = STO.
- HLT handling:
  - In OP_ADDR with `opcode` = HLT, the PC still increments.
  - At the end of that cycle, `halted` is set and `phase` holds at OP_ADDR.
- While halted:
  - `halt` = 1; all other strobes are 0, including `sel`.
  - `phase` is frozen, and `opcode` and `zero` are ignored.
- Resume:
  - `resume` = 1 while halted: on the next edge `halted` clears and `phase` goes to INST_ADDR. Execution continues at PC (the instruction after HLT).
  - `resume` while not halted is ignored.
  - `rst` overrides `resume`. Reset mid-instruction aborts it immediately, with no partial write.
- SKZ with `zero` = 0 consumes a full 8-phase cycle with no effect.
- JMP asserts `ld_pc` in both ALU_OP and STORE. Loading the same value twice is harmless.
- `ld_ac` is never asserted for STO, JMP, SKZ or HLT.
- `wr` and `rd` are never both 1.

Decomposition:
- Package `risc_pkg`: opcode localparams (HLT to JMP), phase localparams (INST_ADDR to STORE), and `OP_W`=3, `PH_W`=3. Shared with the ALU and the top level.
- No sub-module is needed: one sequential block (`phase` + `halted`) and one combinational decode block.

Test Plan:
- Reset: assert `rst` mid-phase 5 → `phase` = 0, `sel` = 1, all other strobes 0, `halt` = 0 asynchronously; release → `phase` counts 0,1,2…7,0.
- ADD (`opcode` = 2): `rd` = 1 in phases 5–7; `ld_ac` = 1 only in phase 7; `wr` = 0 and `data_e` = 0 throughout; `inc_pc` only in phase 4.
- STO (`opcode` = 6): `data_e` = 1 in phases 6–7; `wr` = 1 only in phase 7; `rd` = 0 in phases 5–7; `ld_ac` never 1.
- SKZ (`opcode` = 1) with `zero` = 1 → `inc_pc` in phases 4 and 6. Repeat with `zero` = 0 → `inc_pc` in phase 4 only.
- JMP (`opcode` = 7) → `ld_pc` = 1 in phases 6 and 7, `inc_pc` in phase 4 only.
- HLT (`opcode` = 0): `halt` = 1 and `inc_pc` = 1 in phase 4; `phase` stays 4 for 20 cycles with all strobes 0.
  - `resume` pulse → next cycle `phase` = 0, `sel` = 1, `halt` = 0.
  - `resume` pulses while running cause no phase change.

Source files
------------

// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc_pkg
//  Description : Shared ISA constants for the 8-bit accumulator machine.
//                Covers the opcode encodings, the phase encodings and the
//                field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

  localparam int OP_W = 3;
  localparam int PH_W = 3;

  // Opcode encodings
  localparam logic [OP_W-1:0] HLT = 3'd0;
  localparam logic [OP_W-1:0] SKZ = 3'd1;
  localparam logic [OP_W-1:0] ADD = 3'd2;
  localparam logic [OP_W-1:0] AND = 3'd3;
  localparam logic [OP_W-1:0] XOR = 3'd4;
  localparam logic [OP_W-1:0] LDA = 3'd5;
  localparam logic [OP_W-1:0] STO = 3'd6;
  localparam logic [OP_W-1:0] JMP = 3'd7;

  // Instruction phases; the value sequence is the execution order
  typedef enum logic [PH_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // True for opcodes that read memory and write the accumulator
  function automatic logic is_aluop(input logic [OP_W-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/risc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : risc_controller
//  Description : Eight-phase instruction sequencer. It decodes the opcode
//                and the zero flag into per-phase control strobes. HLT makes
//                the sequencer stick in the halted state until it sees a
//                resume pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module risc_controller
  import risc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            resume,
  output logic            sel,
  output logic            rd,
  output logic            wr,
  output logic            ld_ir,
  output logic            inc_pc,
  output logic            ld_pc,
  output logic            data_e,
  output logic            ld_ac,
  output logic            halt,
  output logic [PH_W-1:0] phase
);

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   w_aluop;

  assign w_aluop = is_aluop(opcode);
  assign phase   = phase_q;

  // State register: phase counter plus sticky halted flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next state: count phases, stop at OP_ADDR on HLT, restart on resume
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (halted_q) begin
      if (resume) begin
        halted_d = 1'b0;
        phase_d  = INST_ADDR;
      end
    end else if ((phase_q == OP_ADDR) && (opcode == HLT)) begin
      halted_d = 1'b1;
    end else begin
      phase_d = phase_t'(phase_q + 3'd1);
    end
  end

  // Strobe decode; while halted, every strobe except halt is forced low
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          // PC steps past the instruction even when it is HLT
          inc_pc = 1'b1;
          halt   = (opcode == HLT);
        end
        OP_FETCH: begin
          rd = w_aluop;
        end
        ALU_OP: begin
          rd     = w_aluop;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          ld_pc  = (opcode == JMP);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_risc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_risc_controller
//  Description : Directed self-checking bench for risc_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_risc_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       resume;
  logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, data_e, ld_ac, halt;
  logic [2:0] phase;
  logic [8:0] strobes;

  int n_tests;
  int n_fail;

  risc_controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .resume (resume),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .halt   (halt),
    .phase  (phase)
  );

  // Strobe word order: sel rd wr ld_ir inc_pc ld_pc data_e ld_ac halt
  assign strobes = {sel, rd, wr, ld_ir, inc_pc, ld_pc, data_e, ld_ac, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand-computed strobe words for phases 0..3 (same for every opcode)
  logic [8:0] fetch_exp [4];
  initial begin
    fetch_exp[0] = 9'h100;  // sel
    fetch_exp[1] = 9'h180;  // sel rd
    fetch_exp[2] = 9'h1A0;  // sel rd ld_ir
    fetch_exp[3] = 9'h1A0;
  end

  // One full 8-phase instruction. Entry and exit: just after a negedge, phase 0.
  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input logic rs, input logic [8:0] e5, input logic [8:0] e6,
                           input logic [8:0] e7);
    logic [8:0] e;
    for (int p = 0; p < 8; p++) begin
      opcode = op;
      zero   = z;
      resume = rs;
      #1;
      if (p < 4)       e = fetch_exp[p];
      else if (p == 4) e = 9'h010;
      else if (p == 5) e = e5;
      else if (p == 6) e = e6;
      else             e = e7;
      check($sformatf("%s ph%0d phase", name, p), {13'd0, phase}, p[15:0]);
      check($sformatf("%s ph%0d strobes", name, p), {7'd0, strobes}, {7'd0, e});
      @(negedge clk);
    end
    resume = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    opcode  = 3'd2;
    zero    = 1'b0;
    resume  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset phase", {13'd0, phase}, 16'd0);
    check("reset strobes", {7'd0, strobes}, 16'h0100);

    // ADD / LDA / AND / XOR: read in 5..7, accumulator load in 7
    run_instr("ADD", 3'd2, 1'b0, 1'b0, 9'h080, 9'h080, 9'h082);
    run_instr("LDA", 3'd5, 1'b1, 1'b0, 9'h080, 9'h080, 9'h082);
    run_instr("AND", 3'd3, 1'b0, 1'b0, 9'h080, 9'h080, 9'h082);
    run_instr("XOR", 3'd4, 1'b0, 1'b0, 9'h080, 9'h080, 9'h082);
    // STO: data_e in 6..7, wr only in 7, no read
    run_instr("STO", 3'd6, 1'b0, 1'b0, 9'h000, 9'h004, 9'h044);
    // SKZ with and without zero
    run_instr("SKZ z1", 3'd1, 1'b1, 1'b0, 9'h000, 9'h010, 9'h000);
    run_instr("SKZ z0", 3'd1, 1'b0, 1'b0, 9'h000, 9'h000, 9'h000);
    // JMP: ld_pc in 6 and 7
    run_instr("JMP", 3'd7, 1'b1, 1'b0, 9'h000, 9'h008, 9'h008);
    // resume while running is ignored
    run_instr("ADD+resume", 3'd2, 1'b0, 1'b1, 9'h080, 9'h080, 9'h082);

    // Asynchronous reset in the middle of phase 5 of a STO
    opcode = 3'd6;
    for (int p = 0; p < 5; p++) @(negedge clk);
    #1;
    check("pre-reset phase", {13'd0, phase}, 16'd5);
    rst = 1'b1;
    #1;
    check("async reset phase", {13'd0, phase}, 16'd0);
    check("async reset strobes", {7'd0, strobes}, 16'h0100);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after reset phase", {13'd0, phase}, 16'd0);
    run_instr("ADD after reset", 3'd2, 1'b0, 1'b0, 9'h080, 9'h080, 9'h082);

    // HLT: halt and inc_pc in phase 4, then frozen
    opcode = 3'd0;
    for (int p = 0; p < 4; p++) @(negedge clk);
    #1;
    check("HLT ph4 phase", {13'd0, phase}, 16'd4);
    check("HLT ph4 strobes", {7'd0, strobes}, 16'h0011);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      opcode = 3'($urandom_range(1, 7));
      zero   = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("halted %0d phase", i), {13'd0, phase}, 16'd4);
      check($sformatf("halted %0d strobes", i), {7'd0, strobes}, 16'h0001);
    end
    resume = 1'b1;
    #1;
    check("resume same cycle", {7'd0, strobes}, 16'h0001);
    @(negedge clk);
    resume = 1'b0;
    #1;
    check("resumed phase", {13'd0, phase}, 16'd0);
    check("resumed strobes", {7'd0, strobes}, 16'h0100);
    run_instr("JMP after resume", 3'd7, 1'b0, 1'b0, 9'h000, 9'h008, 9'h008);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
